kpg_subtractor_pipe: RTL and testbench

- Pipelined 64-bit unsigned subtractor built on the same KPG (kill/propagate/generate) parallel-prefix carry network as the FPM adder path.
- Computes the difference by carry propagation in the reverse sense: a - b = a + ~b + 1, with borrow.
- Used downstream of the Wallace/CLA product stage for exponent difference and mantissa compare/subtract in the FP pipeline.
- Elastic valid/ready handshake on both sides, fixed 3-cycle latency, throughput of one result per cycle.

---
 rtl/kpg_subtractor_pipe.sv | 137 +++++++++++++
 tb/tb_kpg_subtractor_pipe.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kpg_subtractor_pipe.sv
// Three-stage elastic unsigned subtractor: a - b - bin computed as a + ~b + ~bin
// through a KPG parallel-prefix carry network (in-group prefix, then cross-group).
module kpg_subtractor_pipe #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             eq
);
  localparam int NG = WIDTH / 8;

  logic r_v1, r_v2, r_v3;
  logic w_rdy1, w_rdy2, w_rdy3;

  logic [WIDTH-1:0] r_s1_a, r_s1_b;
  logic             r_s1_bin;

  logic [WIDTH-1:0] r_s2_ig, r_s2_ip, r_s2_bp;
  logic             r_s2_cin;

  logic [WIDTH-1:0] r_diff;
  logic             r_bout, r_zero, r_eq;

  assign w_rdy3 = !r_v3 || out_ready;
  assign w_rdy2 = !r_v2 || w_rdy3;
  assign w_rdy1 = !r_v1 || w_rdy2;

  // Per-bit KPG of a[i] and ~b[i], encoded as (generate, propagate); kill = neither.
  logic [WIDTH-1:0] w_bg, w_bp;
  assign w_bg = r_s1_a & ~r_s1_b;
  assign w_bp = r_s1_a ^ ~r_s1_b;

  // Spans 1, 2, 4 inside each byte; descending order keeps the lower operand unmodified.
  logic [WIDTH-1:0] w_ig, w_ip;
  always_comb begin
    w_ig = w_bg;
    w_ip = w_bp;
    for (int s = 1; s < 8; s = s * 2) begin
      for (int gi = 0; gi < NG; gi++) begin
        for (int j = 7; j >= s; j--) begin
          w_ig[gi*8+j] = w_ig[gi*8+j] | (w_ip[gi*8+j] & w_ig[gi*8+j-s]);
          w_ip[gi*8+j] = w_ip[gi*8+j] & w_ip[gi*8+j-s];
        end
      end
    end
  end

  // Cross-group prefix: element 0 is the carry-in, element j+1 is byte j.
  logic [NG:0]      w_xg, w_xp;
  logic [WIDTH-1:0] w_carry, w_diff;
  always_comb begin
    w_xg    = '0;
    w_xp    = '0;
    w_carry = '0;
    w_xg[0] = r_s2_cin;
    for (int gi = 0; gi < NG; gi++) begin
      w_xg[gi+1] = r_s2_ig[gi*8+7];
      w_xp[gi+1] = r_s2_ip[gi*8+7];
    end
    for (int s = 1; s < NG + 1; s = s * 2) begin
      for (int j = NG; j >= s; j--) begin
        w_xg[j] = w_xg[j] | (w_xp[j] & w_xg[j-s]);
        w_xp[j] = w_xp[j] & w_xp[j-s];
      end
    end
    for (int gi = 0; gi < NG; gi++) begin
      w_carry[gi*8] = w_xg[gi];
      for (int k = 1; k < 8; k++)
        w_carry[gi*8+k] = r_s2_ig[gi*8+k-1] | (r_s2_ip[gi*8+k-1] & w_xg[gi]);
    end
    w_diff = r_s2_bp ^ w_carry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_v3     <= 1'b0;
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_s1_bin <= 1'b0;
      r_s2_ig  <= '0;
      r_s2_ip  <= '0;
      r_s2_bp  <= '0;
      r_s2_cin <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_zero   <= 1'b0;
      r_eq     <= 1'b0;
    end else begin
      if (w_rdy1) begin
        r_v1 <= in_valid;
        if (in_valid) begin
          r_s1_a   <= a;
          r_s1_b   <= b;
          r_s1_bin <= bin;
        end
      end
      if (w_rdy2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_s2_ig  <= w_ig;
          r_s2_ip  <= w_ip;
          r_s2_bp  <= w_bp;
          r_s2_cin <= ~r_s1_bin;
        end
      end
      if (w_rdy3) begin
        r_v3 <= r_v2;
        if (r_v2) begin
          r_diff <= w_diff;
          r_bout <= ~w_xg[NG];
          r_zero <= ~|w_diff;
          r_eq   <= &r_s2_bp;
        end
      end
    end
  end

  assign in_ready  = w_rdy1 & ~rst;
  assign out_valid = r_v3;
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign zero      = r_zero;
  assign eq        = r_eq;

endmodule

// File: tb/tb_kpg_subtractor_pipe.sv
// Bench for kpg_subtractor_pipe: directed scenarios plus a randomized stream
// scored against a 65-bit arithmetic model.
module tb_kpg_subtractor_pipe;
  localparam int W  = 64;
  localparam int NR = 10000;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         z;
    logic         e;
  } exp_t;

  logic         clk, rst, in_valid, in_ready, bin, out_valid, out_ready, bout, zero, eq;
  logic [W-1:0] a, b, diff;

  int checks = 0;
  int errors = 0;

  kpg_subtractor_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .zero(zero), .eq(eq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
    logic [W:0] t;
    exp_t r;
    t    = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
    r.d  = t[W-1:0];
    r.bo = t[W];
    r.z  = (t[W-1:0] == '0);
    r.e  = (ma == mb);
    return r;
  endfunction

  task automatic gen(output logic [W-1:0] ga, output logic [W-1:0] gb, output logic gbin);
    ga = {$urandom, $urandom};
    gb = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: gb = ga;
      1: ga = '0;
      2: gb = ga - 1;
      3: gb = ga + 1;
      default: ;
    endcase
    gbin = 1'($urandom_range(0, 1));
  endtask

  // Presents one op with out_ready high; lat counts clock edges from capture to out_valid.
  task automatic do_single(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                           output int lat, output exp_t obs);
    int guard;
    @(negedge clk);
    a = ta; b = tb_; bin = tbin; in_valid = 1'b1; out_ready = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) lat = -1;
    obs = '{d: diff, bo: bout, z: zero, e: eq};
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    #3;
    checks++;
    if ({out_valid, diff, bout, zero, eq} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%h bo=%b z=%b e=%b, expected all zero",
               out_valid, diff, bout, zero, eq);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int lat;
    exp_t obs, exp;
    do_single(64'd5, 64'd3, 1'b0, lat, obs);
    exp = '{d: 64'd2, bo: 1'b0, z: 1'b0, e: 1'b0};
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL basic_latency: got %0d expected 3", lat);
    end
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL basic_result: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_underflow();
    int lat;
    exp_t obs, exp;
    do_single(64'd0, 64'd1, 1'b0, lat, obs);
    exp = '{d: {W{1'b1}}, bo: 1'b1, z: 1'b0, e: 1'b0};
    checks++;
    if (lat != 3 || obs !== exp) begin
      errors++;
      $display("FAIL underflow_0_minus_1: got lat=%0d %h expected lat=3 %h", lat, obs, exp);
    end
    do_single(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, lat, obs);
    exp = '{d: {W{1'b1}}, bo: 1'b1, z: 1'b0, e: 1'b1};
    checks++;
    if (lat != 3 || obs !== exp) begin
      errors++;
      $display("FAIL underflow_eq_bin: got lat=%0d %h expected lat=3 %h", lat, obs, exp);
    end
  endtask

  task automatic test_borrow_chain();
    int lat;
    exp_t obs, exp;
    do_single(64'd0, 64'd0, 1'b0, lat, obs);
    exp = '{d: 64'd0, bo: 1'b0, z: 1'b1, e: 1'b1};
    checks++;
    if (lat != 3 || obs !== exp) begin
      errors++;
      $display("FAIL chain_zero: got lat=%0d %h expected lat=3 %h", lat, obs, exp);
    end
    do_single(64'h0100_0000_0000_0000, 64'd1, 1'b0, lat, obs);
    exp = '{d: 64'h00FF_FFFF_FFFF_FFFF, bo: 1'b0, z: 1'b0, e: 1'b0};
    checks++;
    if (lat != 3 || obs !== exp) begin
      errors++;
      $display("FAIL chain_across_groups: got lat=%0d %h expected lat=3 %h", lat, obs, exp);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] oa[5], ob[5];
    logic         obin[5];
    exp_t         e;
    int acc, outs, first, last;
    for (int i = 0; i < 5; i++) gen(oa[i], ob[i], obin[i]);
    acc = 0;
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (acc < 5);
      if (acc < 5) begin a = oa[acc]; b = ob[acc]; bin = obin[acc]; end
      #1;
      if (in_valid && in_ready) acc++;
      @(negedge clk);
    end
    checks++;
    if (acc != 3 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_full: got accepts=%0d in_ready=%b out_valid=%b expected 3 0 1",
               acc, in_ready, out_valid);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_simultaneous_ready: got %b expected 1", in_ready);
    end
    outs = 0; first = -1; last = -1;
    for (int c = 0; c < 20 && outs < 5; c++) begin
      in_valid = (acc < 5);
      if (acc < 5) begin a = oa[acc]; b = ob[acc]; bin = obin[acc]; end
      out_ready = 1'b1;
      #1;
      if (in_valid && in_ready) acc++;
      if (out_valid) begin
        e = model(oa[outs], ob[outs], obin[outs]);
        checks++;
        if ({diff, bout, zero, eq} !== e) begin
          errors++;
          $display("FAIL bp_result_%0d: got %h expected %h", outs, {diff, bout, zero, eq}, e);
        end
        if (first < 0) first = c;
        last = c;
        outs++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (outs != 5 || acc != 5 || (last - first) != 4) begin
      errors++;
      $display("FAIL bp_drain: got outs=%0d accepts=%0d span=%0d expected 5 5 4",
               outs, acc, last - first);
    end
  endtask

  task automatic test_async_reset();
    int lat, stale;
    exp_t obs, exp;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; a = 64'd100; b = 64'd1; bin = 1'b0;
    @(negedge clk);
    a = 64'd200; b = 64'd2;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, diff, bout, zero, eq} !== '0) begin
      errors++;
      $display("FAIL async_reset_clear: got v=%b d=%h expected v=0 d=0", out_valid, diff);
    end
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL async_reset_stale: got %0d stale outputs expected 0", stale);
    end
    do_single(64'd10, 64'd4, 1'b0, lat, obs);
    exp = '{d: 64'd6, bo: 1'b0, z: 1'b0, e: 1'b0};
    checks++;
    if (lat != 3 || obs !== exp) begin
      errors++;
      $display("FAIL async_reset_fresh: got lat=%0d %h expected lat=3 %h", lat, obs, exp);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] pa, pb;
    logic         pbin, stalled;
    logic [W+3:0] snap;
    exp_t q[$];
    exp_t e;
    int sent, got, cyc;
    gen(pa, pb, pbin);
    sent = 0; got = 0; cyc = 0; stalled = 1'b0; snap = '0;
    while (got < NR && cyc < 60000) begin
      @(negedge clk);
      if (stalled) begin
        checks++;
        if ({out_valid, diff, bout, zero, eq} !== snap) begin
          errors++;
          $display("FAIL rand_stall_hold: got %h expected %h", {out_valid, diff, bout, zero, eq}, snap);
        end
      end
      in_valid  = (sent < NR) && ($urandom_range(0, 9) != 0);
      a = pa; b = pb; bin = pbin;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_unexpected_output: got d=%h expected no output", diff);
        end else begin
          e = q.pop_front();
          if ({diff, bout, zero, eq} !== e) begin
            errors++;
            $display("FAIL rand_result_%0d: got %h expected %h", got, {diff, bout, zero, eq}, e);
          end
        end
        got++;
      end
      stalled = out_valid && !out_ready;
      snap    = {out_valid, diff, bout, zero, eq};
      if (in_valid && in_ready) begin
        q.push_back(model(pa, pb, pbin));
        sent++;
        gen(pa, pb, pbin);
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != NR || q.size() != 0) begin
      errors++;
      $display("FAIL rand_completion: got %0d results (%0d pending) expected %0d", got, q.size(), NR);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_borrow_chain();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
